key_expansion_seq: RTL
======================

// Module: key_expansion_seq
// PURPOSE
//  Iterative AES key schedule feeding the inverse cipher's expanded_key bus.
//  Takes a 128/192/256-bit cipher key plus round count and produces all
//  4*(NR+1) 32-bit words, one word per clock, using a single shared SubWord
//  S-box. Holds the packed result stable until the next accepted start.
// PARAMETERS
//  KEY_W  256   width of i_key; key is left-justified, top Nk words used
//  EXP_W  1920  width of o_expanded_key (60 words max)
// PORTS
//  clk             in   1      single clock, rising edge
//  rst_n           in   1      reset, asynchronous, active-low
//  i_start         in   1      request expansion; sampled only in IDLE/DONE
//  i_nr            in   4      round count: 10, 12 or 14 (Nk = 4, 6, 8)
//  i_key           in   256    cipher key; AES-128 in [255:128], AES-192 in [255:64]
//  o_expanded_key  out  1920   packed schedule (layout below)
//  o_busy          out  1      high in LOAD/EXPAND
//  o_valid         out  1      level; schedule complete and stable
//  o_err           out  1      1-cycle pulse: start rejected for illegal i_nr
// BEHAVIOUR
//  Reset: state=IDLE; word array, o_expanded_key, o_busy, o_valid, o_err all 0.
//  Layout: right-justified. T=4*(NR+1). w[j] at bits [32*(T-j)-1 -: 32].
//   w[T-1] at [31:0]. Round key r at [128*(NR+1-r)-1 -: 128]. Bits above 32*T = 0.
//  FSM: IDLE -> LOAD -> EXPAND -> DONE.
//   IDLE/DONE with i_start=1:
//    i_nr legal: latch key and nr; clear word array; o_valid<=0; go to LOAD.
//    i_nr illegal: o_err=1 for one cycle; state, o_valid and data unchanged.
//   LOAD (1 cycle): w[0..Nk-1] <= key words, i=Nk; go to EXPAND.
//   EXPAND (1 word/cycle): t=w[i-1].
//    if i%Nk==0: t=SubWord(RotWord(t)) ^ {Rcon[i/Nk],24'h0}.
//    else if Nk==8 && i%8==4: t=SubWord(t).
//    w[i]=w[i-Nk]^t. i++. After w[T-1] is written, go to DONE.
//   Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 (GF(2^8) doubling).
//   DONE: o_valid=1, o_busy=0. Data is held until the next legal start.
//  Latency: legal start accepted at cycle 0; o_valid rises at cycle 2+T-Nk.
//   AES-128: 42 cycles. AES-192: 48 cycles. AES-256: 54 cycles.
//  i_start is ignored while o_busy=1; no queuing.
//  i_key and i_nr are sampled only on the accepting edge; later changes have no effect.
//  o_expanded_key is driven from registers. It shows partial words while busy;
//   consumers qualify it with o_valid.
//  Asynchronous reset mid-expansion aborts immediately to the reset values.
//  Loop index i is 6 bits and saturates at T; it never wraps.
// CONFIGURATION
//  KEY_EXP_CACHE_EN defined:
//   Stores the last completed {key, nr}. A legal start whose key and nr match
//   the stored pair, while o_valid=1, skips LOAD and EXPAND. o_valid drops for
//   exactly 1 cycle, then reasserts; the data is unchanged. Reset clears the
//   stored pair.
//  KEY_EXP_CACHE_EN undefined:
//   Every legal start runs the full expansion; no compare logic is built.
// TESTING
//  AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, nr=10 ->
//   w[4]=a0fafe17, w[43]=b6630ca6, o_valid at cycle 42.
//  AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, nr=12 ->
//   w[51]=01002202, o_valid at cycle 48.
//  AES-256 key 603deb10...0914dff4 (FIPS-197 A.3), nr=14 ->
//   w[59]=706c631e, o_valid at cycle 54; exercises the i%8==4 SubWord path.
//  i_nr=11 with start -> o_err 1-cycle pulse, state stays IDLE, o_valid stays 0.
//   A second start while busy is ignored; the result equals the single-start result.
//  rst_n pulsed low at cycle 20 of an AES-128 run -> all outputs 0 asynchronously.
//   A new start then completes correctly in 42 cycles.
//  KEY_EXP_CACHE_EN: repeat the AES-128 start after DONE -> o_valid low 1 cycle,
//   identical data. Changing one key bit -> full 42-cycle run.

Source files
------------

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule (128/192/256): one 32-bit word per clock through a shared SubWord.
// Optional KEY_EXP_CACHE_EN: a repeat start with the same {key, nr} reuses the held schedule.
//
// state  | meaning
// IDLE   | no schedule held since reset
// LOAD   | copy the latched key words into the bottom of the schedule register
// EXPAND | derive one word per cycle; one extra cycle once i reaches T
// DONE   | schedule complete and held, o_valid high
module key_expansion_seq #(
  parameter int KEY_W = 256,
  parameter int EXP_W = 1920
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_nr,
  input  logic [KEY_W-1:0] i_key,
  output logic [EXP_W-1:0] o_expanded_key,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_err
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  state_e           state_q;
  logic [KEY_W-1:0] key_q;
  logic [3:0]       nr_q;
  logic [EXP_W-1:0] exp_q;
  logic [5:0]       i_q;
  logic [3:0]       cnt_q;
  logic [7:0]       rcon_q;
  logic             busy_q, valid_q, err_q;

  logic [3:0]  nk;
  logic [5:0]  t_words;
  logic        nr_legal;
  logic        cache_hit;
  logic [31:0] w_prev, w_back, sub_in, sub_out, w_d;

  assign nk       = nr_q - 4'd6;
  assign t_words  = {nr_q, 2'b00} + 6'd4;
  assign nr_legal = (i_nr == 4'd10) || (i_nr == 4'd12) || (i_nr == 4'd14);
  assign w_prev   = exp_q[31:0];

`ifdef KEY_EXP_CACHE_EN
  assign cache_hit = valid_q && (i_key == key_q) && (i_nr == nr_q);
`else
  assign cache_hit = 1'b0;
`endif

  // Words are shifted in at the bottom, so w[i-1] is always the low word and w[i-Nk] sits Nk words up.
  always_comb begin
    w_back = exp_q[255:224];
    case (nk)
      4'd4:    w_back = exp_q[127:96];
      4'd6:    w_back = exp_q[191:160];
      default: ;
    endcase
    sub_in  = (cnt_q == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (cnt_q == 4'd0)
      w_d = w_back ^ sub_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && cnt_q == 4'd4)
      w_d = w_back ^ sub_out;
    else
      w_d = w_back ^ w_prev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      nr_q    <= '0;
      exp_q   <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      rcon_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) valid_q <= 1'b1;
          if (i_start) begin
            if (!nr_legal) begin
              err_q <= 1'b1;
            end else if (cache_hit) begin
              valid_q <= 1'b0;
            end else begin
              key_q   <= i_key;
              nr_q    <= i_nr;
              exp_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          case (nk)
            4'd4:    exp_q[127:0] <= key_q[KEY_W-1 -: 128];
            4'd6:    exp_q[191:0] <= key_q[KEY_W-1 -: 192];
            default: exp_q[255:0] <= key_q[KEY_W-1 -: 256];
          endcase
          i_q     <= {2'b00, nk};
          cnt_q   <= 4'd0;
          rcon_q  <= 8'h01;
          state_q <= EXPAND;
        end
        EXPAND: begin
          if (i_q != t_words) begin
            exp_q <= {exp_q[EXP_W-33:0], w_d};
            i_q   <= i_q + 6'd1;
            cnt_q <= (cnt_q == nk - 4'd1) ? 4'd0 : cnt_q + 4'd1;
            if (cnt_q == 4'd0)
              rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end else begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_expanded_key = exp_q;
  assign o_busy         = busy_q;
  assign o_valid        = valid_q;
  assign o_err          = err_q;

endmodule
